// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: next-PC input, instruction-memory request/response, decode output.
interface inst_fetch_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] dnpc_i;
    logic              dnpc_valid_i;
    logic              imem_req_valid_o;
    logic              imem_req_ready_i;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_rsp_valid_i;
    logic [DATA_W-1:0] imem_rsp_data_i;
    logic              imem_rsp_err_i;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [ADDR_W-1:0] pc_o;
    logic [DATA_W-1:0] inst_o;
    logic              fetch_fault_o;

    // Fetch unit side
    modport master (
        input  dnpc_i, dnpc_valid_i, imem_req_ready_i, imem_rsp_valid_i,
               imem_rsp_data_i, imem_rsp_err_i, inst_ready_i,
        output imem_req_valid_o, imem_addr_o, inst_valid_o, pc_o, inst_o,
               fetch_fault_o
    );

    // Memory / decode / resolver side
    modport slave (
        output dnpc_i, dnpc_valid_i, imem_req_ready_i, imem_rsp_valid_i,
               imem_rsp_data_i, imem_rsp_err_i, inst_ready_i,
        input  imem_req_valid_o, imem_addr_o, inst_valid_o, pc_o, inst_o,
               fetch_fault_o
    );
endinterface

// File: rtl/inst_fetch.sv
// Fetch stage of the multicycle core: one imem read per instruction, waits for
// the resolved next PC before fetching again, sticky fault on misalignment or bus error.
module inst_fetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input logic          clk,
    input logic          rst,
    inst_fetch_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_NEXT,
        S_FAULT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic              req_valid;
    logic              inst_valid;
    logic              fault;

    logic              rsp_ok_c;
    logic              rsp_bad_c;
    logic              dnpc_take_c;
    logic              dnpc_bad_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and event decode; responses and dnpc only matter in their own states
    always_comb begin
        state_nxt   = state;
        rsp_ok_c    = 1'b0;
        rsp_bad_c   = 1'b0;
        dnpc_take_c = 1'b0;
        dnpc_bad_c  = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                if (bus.imem_req_ready_i) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid_i) begin
                    if (bus.imem_rsp_err_i) begin
                        rsp_bad_c = 1'b1;
                        state_nxt = S_FAULT;
                    end else begin
                        rsp_ok_c  = 1'b1;
                        state_nxt = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (bus.inst_ready_i) begin
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if (bus.dnpc_valid_i) begin
                    dnpc_take_c = 1'b1;
                    if (bus.dnpc_i[1:0] != 2'b00) begin
                        dnpc_bad_c = 1'b1;
                        state_nxt  = S_FAULT;
                    end else begin
                        state_nxt  = S_REQ;
                    end
                end
            end
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs, PC and instruction; valids follow the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid  <= 1'b0;
            inst_valid <= 1'b0;
            fault      <= 1'b0;
            pc         <= RESET_PC;
            inst       <= '0;
        end else begin
            req_valid  <= (state_nxt == S_REQ);
            inst_valid <= (state_nxt == S_OUT);
            if (rsp_bad_c || dnpc_bad_c) begin
                fault <= 1'b1;
            end
            if (dnpc_take_c) begin
                pc <= bus.dnpc_i;
            end
            if (rsp_ok_c) begin
                inst <= bus.imem_rsp_data_i;
            end
        end
    end

    assign bus.imem_req_valid_o = req_valid;
    assign bus.imem_addr_o      = pc;
    assign bus.inst_valid_o     = inst_valid;
    assign bus.pc_o             = pc;
    assign bus.inst_o           = inst;
    assign bus.fetch_fault_o    = fault;

endmodule
